// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port weight/activation memory between NUM_REQ requesters (round-robin,
//   or lowest-index-first when ARB_FIXED_PRIO_EN is defined), with locked bursts and in-order read routing.
// Latency: grant is combinational; memory command 1 cycle after accept; rvalid 1 cycle after mem_valid_out.
// Backpressure: reads are not granted while the owner-tag FIFO is full (writes still are); LOCK stalls others.
module mem_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out,
  input  logic                      mem_valid_out,
  output logic                      err
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BCNT_W = $clog2(MAX_BURST) + 1;
  localparam int FA_W   = $clog2(TAG_DEPTH);
  localparam int FC_W   = FA_W + 1;

  typedef enum logic {ARB, LOCK} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [BCNT_W-1:0] burst_q, burst_d;

  // Owner-tag FIFO: requester index of each outstanding read, oldest at rd_ptr
  logic [IDX_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [IDX_W-1:0]  tag_mem_d [TAG_DEPTH];
  logic [FA_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FA_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]   cnt_q, cnt_d;

  logic              mem_wr_en_q, mem_wr_en_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_REQ-1:0] grantable;
  logic [NUM_REQ-1:0] gnt_c;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   cand_idx;
  logic               found;
  int                 cand;
  logic               fifo_full, fifo_empty;
  logic               accept, push, pop;
  logic [IDX_W-1:0]   rtag;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  assign fifo_full  = (cnt_q == FC_W'(TAG_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // A read cannot be issued without a free tag slot; writes never need one
  assign grantable  = req & (req_we | {NUM_REQ{~fifo_full}});
  // Grant is forced low while reset is asserted even if requests are present
  assign gnt        = gnt_c & {NUM_REQ{rst}};
  assign accept     = |gnt;
  assign push       = accept & ~req_we[win];
  assign pop        = mem_valid_out & ~fifo_empty;
  assign rtag       = tag_mem_q[rd_ptr_q];

  // Arbitration FSM: choose the winner, advance the pointer, track lock owner and burst length
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    gnt_c    = '0;
    win      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    start    = ptr_q;
`ifdef ARB_FIXED_PRIO_EN
    start    = '0;
`endif
    if (state_q == ARB) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(start) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!found && grantable[cand_idx]) begin
          found = 1'b1;
          win   = cand_idx;
        end
      end
      if (found) begin
        gnt_c[win] = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
`endif
        if (req_lock[win] && (MAX_BURST > 1)) begin
          state_d = LOCK;
          owner_d = win;
          burst_d = BCNT_W'(1);
        end
      end
    end else begin
      win = owner_q;
      // Dropping req or lock ends the burst immediately, with no grant this cycle
      if (!req[owner_q] || !req_lock[owner_q]) begin
        state_d = ARB;
      end else if (grantable[owner_q]) begin
        gnt_c[owner_q] = 1'b1;
        burst_d = burst_q + BCNT_W'(1);
        if (burst_d == BCNT_W'(MAX_BURST)) state_d = ARB;
      end
    end
  end

  // Tag FIFO bookkeeping: push on read accept, pop on memory return; both may happen together
  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = win;
      wr_ptr_d = wr_ptr_q + FA_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + FA_W'(1);
    if (push && !pop) cnt_d = cnt_q + FC_W'(1);
    else if (!push && pop) cnt_d = cnt_q - FC_W'(1);
  end

  // Memory command and read-return datapath
  always_comb begin
    mem_wr_en_d   = accept & req_we[win];
    mem_rd_en_d   = push;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    if (accept) begin
      mem_addr_d    = addr_arr[win];
      mem_data_in_d = wdata_arr[win];
    end
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (mem_valid_out) begin
      // A return with no outstanding tag has no owner: drop it and flag the error
      if (fifo_empty) begin
        err_d = 1'b1;
      end else begin
        rvalid_d[rtag] = 1'b1;
        rdata_d        = mem_data_out;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB;
      ptr_q         <= '0;
      owner_q       <= '0;
      burst_q       <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      burst_q       <= burst_d;
      tag_mem_q     <= tag_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 1-cycle memory model.
// The model can withhold returns (hold), be flushed across reset (flush),
// and a spurious return can be injected (spur).
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int NR = 3;
  localparam int AW = 14;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req, req_we, req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_wr_en, mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data_in, mem_data_out;
  logic            mem_valid_out;
  logic            err;

  logic            hold, flush, spur;
  logic [DW-1:0]   spur_dat;
  logic            model_vld = 1'b0;
  logic [DW-1:0]   model_dat = '0;
  logic [DW-1:0]   mem_arr [int];
  logic [DW-1:0]   pend_q [$];

  int checks = 0;
  int failures = 0;
  int rv_cnt [NR];
  logic got;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] exp_gnt;
    logic          exp_rd;
    logic [NR-1:0] exp_rv;
    logic [DW-1:0] exp_rdata;
  } vec_t;
  vec_t tbl [10];

  assign mem_valid_out = model_vld | spur;
  assign mem_data_out  = spur ? spur_dat : model_dat;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TAG_DEPTH(4), .MAX_BURST(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
    .err(err)
  );

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return 32'hC0DE_0000 | {18'h0, a};
  endfunction

  // Memory model: 1-cycle read latency unless returns are withheld
  always @(posedge clk) begin
    if (flush) begin
      pend_q.delete();
    end else begin
      if (mem_wr_en) mem_arr[int'(mem_addr)] = mem_data_in;
      if (mem_rd_en) pend_q.push_back(mem_read(mem_addr));
    end
    if (!flush && !hold && pend_q.size() > 0) begin
      model_vld <= 1'b1;
      model_dat <= pend_q.pop_front();
    end else begin
      model_vld <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (rvalid[i] === 1'b1) rv_cnt[i]++;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NR; i++) rv_cnt[i] = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_wr_en"}, mem_wr_en, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data_in"}, mem_data_in, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Round-robin table: reads from all three requesters for 6 cycles, then drain
`ifdef ARB_FIXED_PRIO_EN
    tbl[0] = '{3'b111, 3'b001, 1'b0, 3'b000, 32'h0};
    tbl[1] = '{3'b111, 3'b001, 1'b1, 3'b000, 32'h0};
    tbl[2] = '{3'b111, 3'b001, 1'b1, 3'b000, 32'h0};
    tbl[3] = '{3'b111, 3'b001, 1'b1, 3'b001, 32'hC0DE0100};
    tbl[4] = '{3'b111, 3'b001, 1'b1, 3'b001, 32'hC0DE0100};
    tbl[5] = '{3'b111, 3'b001, 1'b1, 3'b001, 32'hC0DE0100};
    tbl[6] = '{3'b000, 3'b000, 1'b1, 3'b001, 32'hC0DE0100};
    tbl[7] = '{3'b000, 3'b000, 1'b0, 3'b001, 32'hC0DE0100};
    tbl[8] = '{3'b000, 3'b000, 1'b0, 3'b001, 32'hC0DE0100};
`else
    tbl[0] = '{3'b111, 3'b001, 1'b0, 3'b000, 32'h0};
    tbl[1] = '{3'b111, 3'b010, 1'b1, 3'b000, 32'h0};
    tbl[2] = '{3'b111, 3'b100, 1'b1, 3'b000, 32'h0};
    tbl[3] = '{3'b111, 3'b001, 1'b1, 3'b001, 32'hC0DE0100};
    tbl[4] = '{3'b111, 3'b010, 1'b1, 3'b010, 32'hC0DE0101};
    tbl[5] = '{3'b111, 3'b100, 1'b1, 3'b100, 32'hC0DE0102};
    tbl[6] = '{3'b000, 3'b000, 1'b1, 3'b001, 32'hC0DE0100};
    tbl[7] = '{3'b000, 3'b000, 1'b0, 3'b010, 32'hC0DE0101};
    tbl[8] = '{3'b000, 3'b000, 1'b0, 3'b100, 32'hC0DE0102};
`endif
    tbl[9] = '{3'b000, 3'b000, 1'b0, 3'b000, 32'h0};

    rst = 1'b0; req = '0; req_we = '0; req_lock = '0;
    hold = 1'b0; flush = 1'b1; spur = 1'b0; spur_dat = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = AW'(32'h100 + i);
      req_wdata[i*DW +: DW] = 32'hA5A5_0000 + i;
    end
    clr_cnt();

    // Reset state, with requests present to show gnt is held low
    req = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    req = '0; flush = 1'b0; rst = 1'b1;
    tick();

    // Round-robin fairness and return routing
    for (int r = 0; r < 10; r++) begin
      chk("rr_rd_en", mem_rd_en, tbl[r].exp_rd);
      chk("rr_rvalid", rvalid, tbl[r].exp_rv);
      if (tbl[r].exp_rv != 0) chk("rr_rdata", rdata, tbl[r].exp_rdata);
      req = tbl[r].req; req_we = '0; req_lock = '0;
      #1;
      chk("rr_gnt", gnt, tbl[r].exp_gnt);
      tick();
    end

    // Single write then read from requester 0
    req_addr[0 +: AW] = 14'h0005;
    req_wdata[0 +: DW] = 32'hDEADBEEF;
    req = 3'b001; req_we = 3'b001;
    #1 chk("wr_gnt", gnt, 3'b001);
    tick();
    chk("wr_wr_en", mem_wr_en, 1);
    chk("wr_rd_en", mem_rd_en, 0);
    chk("wr_addr", mem_addr, 14'h0005);
    chk("wr_data_in", mem_data_in, 32'hDEADBEEF);
    req_we = 3'b000;
    #1 chk("rd_gnt", gnt, 3'b001);
    tick();
    chk("rd_rd_en", mem_rd_en, 1);
    chk("rd_wr_en", mem_wr_en, 0);
    chk("rd_addr", mem_addr, 14'h0005);
    req = '0;
    tick();
    chk("rd_rvalid_early", rvalid, 0);
    tick();
    chk("rd_rvalid", rvalid, 3'b001);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_err", err, 0);
    tick();

    // Locked burst by requester 1 with others competing
    clr_cnt();
    req = 3'b010; req_lock = 3'b010; req_we = '0;
    #1 chk("lock_first", gnt, 3'b010);
    tick();
    req = 3'b111;
    for (int i = 1; i < 16; i++) begin
      #1 chk("lock_burst", gnt, 3'b010);
      tick();
    end
`ifdef ARB_FIXED_PRIO_EN
    #1 chk("lock_release", gnt, 3'b001);
`else
    #1 chk("lock_release", gnt, 3'b100);
`endif
    tick();
    #1 chk("lock_next", gnt, 3'b001);
    tick();
    req = '0; req_lock = '0;
    repeat (5) tick();
`ifdef ARB_FIXED_PRIO_EN
    chk("lock_rv0", rv_cnt[0], 2);
    chk("lock_rv2", rv_cnt[2], 0);
`else
    chk("lock_rv0", rv_cnt[0], 1);
    chk("lock_rv2", rv_cnt[2], 1);
`endif
    chk("lock_rv1", rv_cnt[1], 16);

    // Tag FIFO full: reads stall, a write still gets through
    clr_cnt();
    hold = 1'b1; req = 3'b100; req_we = '0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("full_fill", gnt, 3'b100);
      tick();
    end
    req = 3'b101; req_we = 3'b001;
    #1 chk("full_write_gnt", gnt, 3'b001);
    tick();
    chk("full_write_cmd", mem_wr_en, 1);
    req = 3'b100; req_we = '0;
    #1 chk("full_stall", gnt, 3'b000);
    tick();
    #1 chk("full_stall2", gnt, 3'b000);
    chk("full_no_rv", rv_cnt[2], 0);
    hold = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      #1;
      if (gnt === 3'b100) got = 1'b1;
    end
    chk("full_fifth_accept", got, 1);
    tick();
    req = '0;
    repeat (6) tick();
    chk("full_rv2", rv_cnt[2], 5);
    chk("full_rv0", rv_cnt[0], 0);
    chk("full_err", err, 0);

    // Spurious return with nothing outstanding
    spur_dat = 32'h12345678; spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_rvalid", rvalid, 0);
    tick();
    chk("spur_err_hold", err, 1);
    chk("spur_rvalid2", rvalid, 0);

    // Reset in the middle of a locked burst with two reads outstanding
    hold = 1'b1; req = 3'b010; req_lock = 3'b010; req_we = '0;
    #1 chk("mid_gnt1", gnt, 3'b010);
    tick();
    #1 chk("mid_gnt2", gnt, 3'b010);
    tick();
    rst = 1'b0; flush = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    tick();
    req = '0; req_lock = '0;
    tick();
    rst = 1'b1; flush = 1'b0;
    tick();
    clr_cnt();
    req = 3'b111;
    #1 chk("post_rst_ptr0", gnt, 3'b001);
    tick();
    req = 3'b100;
    for (int i = 0; i < 3; i++) begin
      #1 chk("post_rst_fill", gnt, 3'b100);
      tick();
    end
    req = '0;
    hold = 1'b0;
    repeat (8) tick();
    chk("post_rst_rv0", rv_cnt[0], 1);
    chk("post_rst_rv1", rv_cnt[1], 0);
    chk("post_rst_rv2", rv_cnt[2], 3);
    chk("post_rst_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
